// File: rtl/adc_serial_responder_pkg.sv
// adc_serial_responder_pkg: frame state encodings and default link geometry shared by
// the responder, the ADC receiver and the bench.
package adc_serial_responder_pkg;
   localparam int DATA_W_DEF      = 12;
   localparam int LEAD_ZEROS_DEF  = 4;
   localparam int FIFO_DEPTH_DEF  = 4;
   localparam int SYNC_STAGES_DEF = 2;
   typedef enum logic [1:0] {IDLE, LEAD, DATA, TAIL} state_t;
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/adc_serial_responder_if.sv
// adc_serial_responder_if: sample push port plus the serial link toward the ADC receiver.
interface adc_serial_responder_if
   import adc_serial_responder_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
   logic                             CS;
   logic                             sclk_in;
   logic [DATA_W-1:0]                sample_in;
   logic                             sample_valid;
   logic                             sample_ready;
   logic                             data_ADC;
   logic                             data_oe;
   logic                             frame_done;
   logic                             underrun;
   logic                             abort;
   logic [level_w(FIFO_DEPTH)-1:0]   fifo_level;
   modport master (
      output CS, sclk_in, sample_in, sample_valid,
      input  sample_ready, data_ADC, data_oe, frame_done, underrun, abort, fifo_level
   );
   modport slave (
      input  CS, sclk_in, sample_in, sample_valid,
      output sample_ready, data_ADC, data_oe, frame_done, underrun, abort, fifo_level
   );
endinterface

// File: rtl/adc_serial_responder_sync_edge_det.sv
// sync_edge_det: multi-stage synchroniser for an asynchronous pin; exposes the synced level
// and a one-cycle change pulse, from which rise/fall are (chg & lvl) and (chg & ~lvl).
module sync_edge_det
   import adc_serial_responder_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_DEF
) (
   input  logic clock_In,
   input  logic Reset,
   input  logic d,
   output logic lvl,
   output logic chg
);
   logic [STAGES-1:0] s;
   logic              prev;
   always_ff @(posedge clock_In)
      if (Reset) begin
         s    <= '0;
         prev <= 1'b0;
      end else begin
         s    <= {s[STAGES-2:0], d};
         prev <= s[STAGES-1];
      end
   assign lvl = s[STAGES-1];
   assign chg = lvl ^ prev;
endmodule

// File: rtl/adc_serial_responder.sv
// adc_serial_responder: buffers samples and shifts LEAD_ZEROS zeros then the sample MSB-first
// on each synchronised sclk fall while CS is low, emulating the serial ADC transmitter.
module adc_serial_responder
   import adc_serial_responder_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int LEAD_ZEROS  = LEAD_ZEROS_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input logic                   clock_In,
   input logic                   Reset,
   adc_serial_responder_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = level_w(FIFO_DEPTH);
   localparam int KW = $clog2(LEAD_ZEROS + DATA_W + 1);
   localparam logic [KW-1:0] K_MSB = KW'(LEAD_ZEROS - 1);
   localparam logic [KW-1:0] K_END = KW'(LEAD_ZEROS + DATA_W - 1);
   localparam logic [LW-1:0] FULL  = LW'(FIFO_DEPTH);
   state_t            state;
   logic [KW-1:0]     k;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic              cs_lvl, cs_chg, sclk_lvl, sclk_chg;
   logic              cs_rise, cs_fall, sclk_fall, empty, push, pop;
   logic [LW-1:0]     level_nx;
   sync_edge_det #(.STAGES(SYNC_STAGES)) u_cs (
      .clock_In(clock_In), .Reset(Reset), .d(bus.CS), .lvl(cs_lvl), .chg(cs_chg)
   );
   sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk (
      .clock_In(clock_In), .Reset(Reset), .d(bus.sclk_in), .lvl(sclk_lvl), .chg(sclk_chg)
   );
   always_comb begin
      cs_rise   = cs_chg & cs_lvl;
      cs_fall   = cs_chg & ~cs_lvl;
      sclk_fall = sclk_chg & ~sclk_lvl;
      empty     = bus.fifo_level == '0;
      push      = bus.sample_valid & bus.sample_ready;
      pop       = (state == IDLE) & cs_fall & ~empty;
      level_nx  = bus.fifo_level + LW'(push) - LW'(pop);
   end
   always_ff @(posedge clock_In)
      if (push) mem[wr_ptr] <= bus.sample_in;
   always_ff @(posedge clock_In)
      if (Reset) begin
         state            <= IDLE;
         k                <= '0;
         shreg            <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         bus.data_ADC     <= 1'b0;
         bus.data_oe      <= 1'b0;
         bus.frame_done   <= 1'b0;
         bus.underrun     <= 1'b0;
         bus.abort        <= 1'b0;
         bus.sample_ready <= 1'b1;
         bus.fifo_level   <= '0;
      end else begin
         bus.frame_done   <= 1'b0;
         bus.underrun     <= 1'b0;
         bus.abort        <= 1'b0;
         bus.fifo_level   <= level_nx;
         bus.sample_ready <= level_nx != FULL;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case (state)
            IDLE:
               if (cs_fall) begin
                  shreg        <= empty ? '0 : mem[rd_ptr];
                  bus.underrun <= empty;
                  k            <= '0;
                  bus.data_oe  <= 1'b1;
                  bus.data_ADC <= 1'b0;
                  state        <= LEAD;
               end
            LEAD, DATA:
               // CS rise outranks a coincident sclk fall; the popped sample is dropped
               if (cs_rise) begin
                  state        <= IDLE;
                  bus.data_ADC <= 1'b0;
                  bus.data_oe  <= 1'b0;
                  bus.abort    <= 1'b1;
               end else if (sclk_fall) begin
                  k <= k + 1'b1;
                  if (state == LEAD) begin
                     if (k == K_MSB) begin
                        bus.data_ADC <= shreg[DATA_W-1];
                        state        <= DATA;
                     end
                  end else begin
                     shreg          <= shreg << 1;
                     bus.data_ADC   <= (k == K_END) ? 1'b0 : shreg[DATA_W-2];
                     bus.frame_done <= k == K_END;
                     if (k == K_END) state <= TAIL;
                  end
               end
            TAIL:
               if (cs_rise) begin
                  state       <= IDLE;
                  bus.data_oe <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_adc_serial_responder.sv
// tb_adc_serial_responder: randomized scenarios checked against a queue-based model of the
// sample buffer and a bit-position formula for the serial frame.
module tb_adc_serial_responder;
   import adc_serial_responder_pkg::*;
   localparam int DW    = DATA_W_DEF;
   localparam int LZ    = LEAD_ZEROS_DEF;
   localparam int DEPTH = FIFO_DEPTH_DEF;
   localparam int HALF  = 6;
   logic clock_In = 1'b0;
   logic Reset    = 1'b1;
   int checks = 0, failures = 0;
   int n_done = 0, n_under = 0, n_abort = 0;
   logic [DW-1:0] q[$];
   adc_serial_responder_if bus ();
   adc_serial_responder dut (.clock_In(clock_In), .Reset(Reset), .bus(bus));
   always #5 clock_In = ~clock_In;
   always @(posedge clock_In) begin
      n_done  += int'(bus.frame_done);
      n_under += int'(bus.underrun);
      n_abort += int'(bus.abort);
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clock_In);
   endtask
   task automatic push_sample(input logic [DW-1:0] v);
      bus.sample_in    = v;
      bus.sample_valid = 1'b1;
      cyc(1);
      bus.sample_valid = 1'b0;
      if (q.size() < DEPTH) q.push_back(v);
      checks++;
      if (int'(bus.fifo_level) !== q.size()) begin
         failures++;
         $display("FAIL push_level got=%0d exp=%0d", bus.fifo_level, q.size());
      end
      checks++;
      if (bus.sample_ready !== (q.size() < DEPTH)) begin
         failures++;
         $display("FAIL push_ready got=%b exp=%b", bus.sample_ready, q.size() < DEPTH);
      end
   endtask
   task automatic run_frame(input int falls, input bit end_cs, input bit do_push, input logic [DW-1:0] pv);
      logic [DW-1:0] exp;
      logic          expb;
      bit            und, acc;
      int            d0, u0, a0;
      d0  = n_done;
      u0  = n_under;
      a0  = n_abort;
      acc = q.size() < DEPTH;
      und = q.size() == 0;
      exp = und ? '0 : q.pop_front();
      bus.CS = 1'b0;
      cyc(2);
      if (do_push) begin
         bus.sample_in    = pv;
         bus.sample_valid = 1'b1;
      end
      cyc(1);
      bus.sample_valid = 1'b0;
      if (do_push && acc) q.push_back(pv);
      cyc(HALF - 3);
      checks++;
      if (bus.data_oe !== 1'b1 || bus.data_ADC !== 1'b0) begin
         failures++;
         $display("FAIL frame_open oe=%b data=%b exp oe=1 data=0", bus.data_oe, bus.data_ADC);
      end
      for (int i = 1; i <= falls; i++) begin
         bus.sclk_in = 1'b0;
         cyc(HALF);
         expb = (i >= LZ && i < LZ + DW) ? exp[DW-1-(i-LZ)] : 1'b0;
         checks++;
         if (bus.data_ADC !== expb) begin
            failures++;
            $display("FAIL bit fall=%0d sample=%h got=%b exp=%b", i, exp, bus.data_ADC, expb);
         end
         bus.sclk_in = 1'b1;
         cyc(HALF);
      end
      checks++;
      if (n_under - u0 !== int'(und)) begin
         failures++;
         $display("FAIL underrun_pulses got=%0d exp=%0d", n_under - u0, und);
      end
      if (end_cs) begin
         bus.CS = 1'b1;
         cyc(HALF);
         checks++;
         if (bus.data_oe !== 1'b0 || bus.data_ADC !== 1'b0) begin
            failures++;
            $display("FAIL frame_close oe=%b data=%b exp oe=0 data=0", bus.data_oe, bus.data_ADC);
         end
         checks++;
         if (n_done - d0 !== int'(falls >= LZ + DW)) begin
            failures++;
            $display("FAIL frame_done_pulses falls=%0d got=%0d exp=%0d", falls, n_done - d0, falls >= LZ + DW);
         end
         checks++;
         if (n_abort - a0 !== int'(falls < LZ + DW)) begin
            failures++;
            $display("FAIL abort_pulses falls=%0d got=%0d exp=%0d", falls, n_abort - a0, falls < LZ + DW);
         end
         checks++;
         if (int'(bus.fifo_level) !== q.size() || bus.sample_ready !== (q.size() < DEPTH)) begin
            failures++;
            $display("FAIL frame_level got=%0d/%b exp=%0d/%b", bus.fifo_level, bus.sample_ready, q.size(), q.size() < DEPTH);
         end
      end
   endtask
   task automatic test_reset;
      Reset = 1'b1;
      cyc(3);
      checks++;
      if ({bus.data_ADC, bus.data_oe, bus.frame_done, bus.underrun, bus.abort} !== 5'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=00000", {bus.data_ADC, bus.data_oe, bus.frame_done, bus.underrun, bus.abort});
      end
      checks++;
      if (bus.sample_ready !== 1'b1 || bus.fifo_level !== '0) begin
         failures++;
         $display("FAIL reset_fifo ready=%b level=%0d exp 1/0", bus.sample_ready, bus.fifo_level);
      end
      Reset = 1'b0;
      cyc(HALF);
   endtask
   task automatic test_single;
      push_sample(12'hA5C);
      run_frame(16, 1'b1, 1'b0, '0);
   endtask
   task automatic test_underrun;
      run_frame(16, 1'b1, 1'b0, '0);
   endtask
   task automatic test_fill;
      for (int i = 0; i < 5; i++) push_sample(DW'($urandom));
      run_frame(16, 1'b1, 1'b0, '0);
   endtask
   task automatic test_abort;
      run_frame(7, 1'b1, 1'b0, '0);
      run_frame(16, 1'b1, 1'b0, '0);
   endtask
   task automatic test_reset_mid;
      int a0;
      push_sample(DW'($urandom));
      a0 = n_abort;
      run_frame(10, 1'b0, 1'b0, '0);
      Reset = 1'b1;
      cyc(1);
      q.delete();
      checks++;
      if (bus.data_ADC !== 1'b0 || bus.data_oe !== 1'b0 || bus.sample_ready !== 1'b1 || bus.fifo_level !== '0) begin
         failures++;
         $display("FAIL midframe_reset data=%b oe=%b ready=%b level=%0d exp 0/0/1/0", bus.data_ADC, bus.data_oe, bus.sample_ready, bus.fifo_level);
      end
      Reset = 1'b0;
      bus.CS = 1'b1;
      cyc(HALF);
      checks++;
      if (n_abort !== a0) begin
         failures++;
         $display("FAIL midframe_reset_abort got=%0d exp=0", n_abort - a0);
      end
   endtask
   task automatic test_back_to_back;
      int lvl0;
      push_sample(DW'($urandom));
      push_sample(DW'($urandom));
      lvl0 = int'(bus.fifo_level);
      run_frame(16, 1'b1, 1'b1, 12'h001);
      run_frame(16, 1'b1, 1'b1, 12'hFFF);
      checks++;
      if (int'(bus.fifo_level) !== lvl0) begin
         failures++;
         $display("FAIL push_at_pop_level got=%0d exp=%0d", bus.fifo_level, lvl0);
      end
      run_frame(16, 1'b1, 1'b0, '0);
      run_frame(16, 1'b1, 1'b0, '0);
   endtask
   task automatic test_random;
      for (int n = 0; n < 8; n++) begin
         for (int p = $urandom_range(0, 3); p > 0; p--) push_sample(DW'($urandom));
         run_frame($urandom_range(1, 20), 1'b1, 1'($urandom_range(0, 1)), DW'($urandom));
      end
   endtask
   initial begin
      bus.CS           = 1'b1;
      bus.sclk_in      = 1'b1;
      bus.sample_in    = '0;
      bus.sample_valid = 1'b0;
      test_reset;
      test_single;
      test_underrun;
      test_fill;
      test_abort;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
